// File: rtl/acc_pe_unit.sv
// Lane-wise accumulator (1x32 / 4x8 / 2x16) with OFF/ARM/ACC control and a small result FIFO.
// Results appear one cycle after the match cycle; full-buffer pushes without a pop are dropped (sticky overflow).
module acc_pe_unit #(
  parameter int NBIT       = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            reg_is_acc_i,
  input  logic [1:0]      reg_acc_vec_mode_i,
  input  logic [NBIT-1:0] reg_acc_init_i,
  input  logic            op_valid_i,
  input  logic [NBIT-1:0] op_data_i,
  input  logic            match_d_i,
  output logic            res_valid_o,
  output logic [NBIT-1:0] res_data_o,
  input  logic            res_ready_i,
  output logic            overflow_o,
  output logic            busy_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {ST_OFF, ST_ARM, ST_ACC} state_e;

  state_e          state_q, state_d;
  logic [NBIT-1:0] acc_q, acc_d;
  logic [NBIT-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     cnt_q, cnt_d;
  logic            ovf_q;

  logic [NBIT-1:0] operand, sum;
  logic            push, clr, pop, full, push_ok, drop;

  // Carries are cut at lane boundaries so each lane wraps independently.
  function automatic logic [NBIT-1:0] lane_add(input logic [NBIT-1:0] a,
                                               input logic [NBIT-1:0] b,
                                               input logic [1:0]      mode);
    logic [NBIT-1:0] s;
    s = '0;
    case (mode)
      2'b01:   for (int i = 0; i < NBIT/8; i++)  s[i*8 +: 8]   = a[i*8 +: 8]   + b[i*8 +: 8];
      2'b10:   for (int i = 0; i < NBIT/16; i++) s[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
      default: s = a + b;
    endcase
    return s;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign operand = op_valid_i ? op_data_i : '0;
  assign sum     = lane_add(acc_q, operand, reg_acc_vec_mode_i);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    push    = 1'b0;
    clr     = 1'b0;
    if (!reg_is_acc_i) begin
      state_d = ST_OFF;
      clr     = 1'b1;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_ARM;
          clr     = 1'b1;
        end
        ST_ARM: begin
          if (match_d_i) begin
            state_d = ST_ACC;
            acc_d   = lane_add(reg_acc_init_i, operand, reg_acc_vec_mode_i);
          end
        end
        ST_ACC: begin
          if (match_d_i) begin
            push  = 1'b1;
            acc_d = reg_acc_init_i;
          end else begin
            acc_d = sum;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
    if (clr) acc_d = '0;
  end

  assign pop     = res_valid_o && res_ready_i;
  assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_OFF;
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      if (clr) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
        cnt_q <= cnt_d;
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

  // Storage needs no reset: the output is gated to zero while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clr) mem_q[wr_ptr_q] <= sum;
  end

  assign res_valid_o = (cnt_q != '0);
  assign res_data_o  = res_valid_o ? mem_q[rd_ptr_q] : '0;
  assign overflow_o  = ovf_q;
  assign busy_o      = (state_q == ST_ACC) || res_valid_o;

endmodule

// File: doc/acc_pe_unit.md
ACC_PE_UNIT -- requirements
Module: acc_pe_unit

Interface
REQ-001 SHALL have parameter NBIT, default 32, meaning accumulator/operand width; legal value 32 only (vector lanes assume 32).
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning result buffer entries; legal values 2 and 4.
REQ-003 SHALL have port clk_i, input, 1, clock; reset rst_n_i, asynchronous, active-low.
REQ-004 SHALL have port rst_n_i, input, 1, async active-low reset.
REQ-005 SHALL have port reg_is_acc_i, input, 1, accumulation enable; 0 forces OFF state.
REQ-006 SHALL have port reg_acc_vec_mode_i, input, 2, lane mode: 00 = 1x32, 01 = 4x8, 10 = 2x16, 11 = treated as 00.
REQ-007 SHALL have port reg_acc_init_i, input, NBIT, accumulation restart value.
REQ-008 SHALL have port op_valid_i, input, 1, operand valid this cycle.
REQ-009 SHALL have port op_data_i, input, NBIT, operand (lane-packed, lane 0 at LSBs).
REQ-010 SHALL have port match_d_i, input, 1, delayed accumulation-done pulse from the accumulation controller.
REQ-011 SHALL have port res_valid_o, output, 1, result buffer non-empty.
REQ-012 SHALL have port res_data_o, output, NBIT, head-of-buffer result.
REQ-013 SHALL have port res_ready_i, input, 1, consumer accepts head result.
REQ-014 SHALL have port overflow_o, output, 1, sticky: a result was dropped.
REQ-015 SHALL have port busy_o, output, 1, high in ACC state or when buffer non-empty.

Function
REQ-016 SHALL implement FSM OFF/ARM/ACC; OFF->ARM when reg_is_acc_i=1; ARM->ACC on match_d_i=1; any state->OFF (next cycle) when reg_is_acc_i=0.
REQ-017 SHALL in OFF hold acc_q=0, empty the buffer, clear overflow_o.
REQ-018 SHALL in ARM ignore op_valid_i unless match_d_i=1; on match_d_i load acc_q <= init + (op_valid_i ? op : 0), push nothing.
REQ-019 SHALL in ACC with op_valid_i=1, match_d_i=0 update acc_q <= acc_q + op_data_i lane-wise.
REQ-020 SHALL in ACC with match_d_i=1 push final = acc_q + (op_valid_i ? op : 0) and reload acc_q <= reg_acc_init_i in the same cycle.
REQ-021 SHALL perform lane-wise modular add: no carry between lanes; each lane wraps modulo 2^lane_width.
REQ-022 SHALL sample reg_acc_vec_mode_i each add; mode change mid-window is undefined for that window only.
REQ-023 SHALL make a pushed result visible on res_valid_o/res_data_o the cycle after the match cycle (1-cycle latency).
REQ-024 SHALL pop head when res_valid_o && res_ready_i; res_data_o stable while res_valid_o=1 and not popped.
REQ-025 SHALL on push when full and no pop in the same cycle drop the new result and set overflow_o; push with simultaneous pop when full SHALL succeed.
REQ-026 SHALL keep FIFO order; pointers wrap modulo FIFO_DEPTH.
REQ-027 SHALL on reg_is_acc_i falling mid-window discard acc_q and buffer contents (no flush to consumer).

Reset
REQ-028 SHALL on rst_n_i=0 asynchronously set state=OFF, acc_q=0, buffer empty, res_valid_o=0, res_data_o=0, overflow_o=0, busy_o=0.

Verification
REQ-029 Mode 00, init=5, arm match, ops 1,2,3, match with op 4 -> res_data_o=15 one cycle later, acc_q reloaded to 5.
REQ-030 Mode 01, init=0, ops 0x80FF0101 twice, match no op -> result 0x00FE0202 (lane wrap, no cross-lane carry).
REQ-031 Mode 10, res_ready_i=0, three match windows with FIFO_DEPTH=2 -> two results held in order, third dropped, overflow_o=1.
REQ-032 Buffer full, match and res_ready_i=1 same cycle -> new result accepted, overflow_o stays 0.
REQ-033 Mid-window reg_is_acc_i=0 then 1, or rst_n_i pulse -> state ARM, res_valid_o=0, overflow_o=0, first match after produces no result.
